alu_sequencer: RTL and testbench
================================

# alu_sequencer

Issue-side controller for the ArithmeticLogicalUnit datapath. It accepts one operation at a time over a valid/ready handshake and muxes RB between register and immediate. It drives the ALU for a fixed number of cycles, captures RZ and the N/Z/V/C flags into the 32-bit Condition Control Register (CCR), and presents the result on a writeback handshake. NOP, unrecognized instructions and unrecognized formats are retired in the controller and never reach the ALU.

## Interface
- WIDTH, 32, datapath width.
- ALU_LATENCY, 1, cycles from ALU inputs stable to ALU_RZ valid; legal range 1..15.

- Clock  in  1  single clock, rising edge.
- Reset  in  1  synchronous, active-high.
- IssueValid  in  1  issue request.
- IssueReady  out  1  controller can accept.
- IssueOp  in  6  opcode; 6'h3F = NOP; 6'h00..6'h0F recognized; all others unrecognized.
- IssueFmt  in  2  instruction format; 2'b11 unrecognized.
- IssueA / IssueB / IssueImm  in  WIDTH  operands and immediate.
- IssueUseImm  in  1  RB source: 1 = IssueImm, 0 = IssueB.
- IssueDest  in  5  destination register tag.
- ALU_Op  out  32  {26'b0, opcode}.
- ALU_RA / ALU_RB  out  WIDTH  operands to ALU.
- ALU_NOP  out  1  drives the ALU NOP_FLAG input; 0 only in EXEC.
- ALU_RZ  in  WIDTH  ALU result.
- ALU_C / ALU_V  in  1  ALU carry / overflow.
- WbValid  out  1  result available.
- WbReady  in  1  consumer accepts.
- WbData  out  WIDTH  captured result.
- WbDest  out  5  captured destination.
- CcrClear  in  1  clears CCR[6:0].
- CCR  out  32  bit0 C, bit1 N, bit2 V, bit3 Z, bit4 INR, bit5 IFNR, bit6 NOP, bits[31:7] = 0.
- Busy  out  1  state != IDLE.

## Operation
- FSM states: IDLE, EXEC, WB.
- IssueReady = (state == IDLE) & ~Reset. An issue is accepted on any rising edge where IssueValid & IssueReady.
- Classification of an accepted issue, in priority order:
  - IssueFmt == 2'b11: set IFNR, clear INR and NOP, stay IDLE.
  - IssueOp == 6'h3F: set NOP, clear INR and IFNR, stay IDLE.
  - IssueOp > 6'h0F: set INR, clear IFNR and NOP, stay IDLE.
  - These three cases produce no writeback and leave N/Z/V/C unchanged.
  - Otherwise register ALU_Op, ALU_RA = IssueA, ALU_RB = IssueUseImm ? IssueImm : IssueB, and WbDest; load the counter with ALU_LATENCY-1; go to EXEC.
- EXEC:
  - Counter decrements each cycle.
  - At count 0: WbData <= ALU_RZ; Z <= (ALU_RZ == 0); N <= ALU_RZ[WIDTH-1]; C <= ALU_C; V <= ALU_V; clear INR, IFNR and NOP; go to WB.
- WB:
  - WbValid = 1 and WbData/WbDest are held stable until WbReady.
  - On the WbReady edge, go to IDLE.
- CcrClear zeroes CCR[6:0]. If it coincides with an EXEC capture or a classification update, the clear is applied first, then the update; the net CCR shows the new flags.
- ALU_Op, ALU_RA and ALU_RB hold their last values outside EXEC.

## Timing
- Reset values: state IDLE, IssueReady 0 while Reset is high, WbValid 0, WbData 0, WbDest 0, CCR 0, ALU_Op/RA/RB 0, ALU_NOP 1, Busy 0.
- Accept edge k: ALU inputs are valid from cycle k+1. Capture occurs at edge k+ALU_LATENCY. WbValid is high from cycle k+ALU_LATENCY+1.
- With WbReady tied high, minimum issue-to-issue spacing is ALU_LATENCY+2 cycles.
- NOP, INR and IFNR retire in 1 cycle; CCR is updated on the accept edge; IssueReady stays high.
- Reset mid-operation (EXEC or WB): the operation is discarded with no writeback, and all outputs take reset values on that edge.
- WbReady high while WbValid is low is ignored.

## Configuration
- ALU_SEQ_STICKY_OVF_EN defined: at capture, V <= V | ALU_V. V is cleared only by CcrClear or Reset; NOP, INR and IFNR do not clear it.
- ALU_SEQ_STICKY_OVF_EN undefined: V <= ALU_V on every capture.

## Test plan
- ALU_LATENCY=1, WbReady=1, ADD op 6'h01, A=5, B=7, ALU_RZ=12 -> WbValid is high 2 cycles after accept with WbData=12; CCR=0.
- IssueUseImm=1, IssueB=9, IssueImm=32'hFFFF_FFFF -> ALU_RB=32'hFFFF_FFFF. With ALU_RZ=32'h8000_0000 and ALU_C=1: CCR=32'h03 (N, C).
- IssueOp=6'h3F, then 6'h20, then IssueFmt=2'b11 on consecutive cycles -> CCR[6], then CCR[4], then CCR[5] is the only set bit among [6:4]. N/Z/V/C unchanged, no WbValid, IssueReady stays 1.
- ALU_LATENCY=3, WbReady held 0 for 4 cycles -> WbData is stable, IssueReady is 0 throughout, and the next issue is accepted the cycle after WbReady rises.
- Op with ALU_V=1, then op with ALU_V=0 -> CCR[2]=1 with the macro defined, 0 without. After CcrClear, CCR[2]=0.
- Reset asserted during EXEC -> next cycle WbValid=0, CCR=0, IssueReady=1, and no writeback ever appears.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer
// Issue-side controller for the ArithmeticLogicalUnit datapath. Accepts one
// operation at a time, drives the ALU for ALU_LATENCY cycles, captures the
// result and N/Z/V/C into CCR, then presents the result on a writeback
// handshake. NOP, unrecognized opcodes and unrecognized formats retire here
// and never reach the ALU.
//
// Ports:
//   Clock, Reset          rising-edge clock, synchronous active-high reset
//   Issue*                issue handshake, opcode, format, operands, dest tag
//   ALU_Op/RA/RB/NOP      ALU drive; ALU_NOP is low only while executing
//   ALU_RZ/C/V            ALU result and carry/overflow
//   Wb*                   writeback handshake, result and dest tag
//   CcrClear, CCR         flag clear request, condition control register
//   Busy                  controller is not idle
//
// Build option: define ALU_SEQ_STICKY_OVF_EN to make CCR.V accumulate across
// captures (cleared only by CcrClear or Reset).
module alu_sequencer #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             IssueValid,
  output logic             IssueReady,
  input  logic [5:0]       IssueOp,
  input  logic [1:0]       IssueFmt,
  input  logic [WIDTH-1:0] IssueA,
  input  logic [WIDTH-1:0] IssueB,
  input  logic [WIDTH-1:0] IssueImm,
  input  logic             IssueUseImm,
  input  logic [4:0]       IssueDest,
  output logic [31:0]      ALU_Op,
  output logic [WIDTH-1:0] ALU_RA,
  output logic [WIDTH-1:0] ALU_RB,
  output logic             ALU_NOP,
  input  logic [WIDTH-1:0] ALU_RZ,
  input  logic             ALU_C,
  input  logic             ALU_V,
  output logic             WbValid,
  input  logic             WbReady,
  output logic [WIDTH-1:0] WbData,
  output logic [4:0]       WbDest,
  input  logic             CcrClear,
  output logic [31:0]      CCR,
  output logic             Busy
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FLAG_W = 7;
  localparam int unsigned F_C    = 0;
  localparam int unsigned F_N    = 1;
  localparam int unsigned F_V    = 2;
  localparam int unsigned F_Z    = 3;
  localparam int unsigned F_INR  = 4;
  localparam int unsigned F_NOP  = 6;
  localparam logic [5:0]  OP_NOP = 6'h3F;
  localparam logic [5:0]  OP_MAX = 6'h0F;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [5:0]         op_q, op_d;
  logic [WIDTH-1:0]   ra_q, ra_d;
  logic [WIDTH-1:0]   rb_q, rb_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [4:0]         dest_q, dest_d;
  logic [FLAG_W-1:0]  flags_q, flags_d;
  logic               alu_nop_q, alu_nop_d;
  logic               accept;

  assign IssueReady = (state_q == IDLE) & ~Reset;
  assign accept     = IssueValid & IssueReady;

  // Next-state, datapath capture and flag update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    data_d  = data_q;
    dest_d  = dest_q;
    // Clear takes effect first so a same-edge update still lands
    flags_d = CcrClear ? '0 : flags_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          // {NOP, IFNR, INR} are mutually exclusive retirement markers
          if (IssueFmt == 2'b11) begin
            flags_d[F_NOP:F_INR] = 3'b010;
          end else if (IssueOp == OP_NOP) begin
            flags_d[F_NOP:F_INR] = 3'b100;
          end else if (IssueOp > OP_MAX) begin
            flags_d[F_NOP:F_INR] = 3'b001;
          end else begin
            op_d    = IssueOp;
            ra_d    = IssueA;
            rb_d    = IssueUseImm ? IssueImm : IssueB;
            dest_d  = IssueDest;
            cnt_d   = CNT_W'(ALU_LATENCY - 1);
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          data_d               = ALU_RZ;
          flags_d[F_Z]         = (ALU_RZ == '0);
          flags_d[F_N]         = ALU_RZ[WIDTH-1];
          flags_d[F_C]         = ALU_C;
`ifdef ALU_SEQ_STICKY_OVF_EN
          flags_d[F_V]         = flags_d[F_V] | ALU_V;
`else
          flags_d[F_V]         = ALU_V;
`endif
          flags_d[F_NOP:F_INR] = 3'b000;
          state_d              = WB;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WB: begin
        if (WbReady) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    alu_nop_d = (state_d != EXEC);
  end

  // State and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      data_q    <= '0;
      dest_q    <= '0;
      flags_q   <= '0;
      alu_nop_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      data_q    <= data_d;
      dest_q    <= dest_d;
      flags_q   <= flags_d;
      alu_nop_q <= alu_nop_d;
    end
  end

  assign ALU_Op  = {26'b0, op_q};
  assign ALU_RA  = ra_q;
  assign ALU_RB  = rb_q;
  assign ALU_NOP = alu_nop_q;
  assign WbValid = (state_q == WB);
  assign WbData  = data_q;
  assign WbDest  = dest_q;
  assign CCR     = {(32 - FLAG_W)'(0), flags_q};
  assign Busy    = (state_q != IDLE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: one instance at ALU_LATENCY=1 and one at
// ALU_LATENCY=3, each driven by a behavioural ALU. Expected results come from
// a reference model of the issue/execute/writeback contract.
module tb_alu_sequencer;

  logic        Clock;
  logic        Reset;
  logic [5:0]  op;
  logic [1:0]  fmt;
  logic [31:0] a, b, imm;
  logic        useimm;
  logic [4:0]  dest;
  logic        clr;

  logic        iv1, rdy1, nop1, c1, v1, wv1, wr1, busy1;
  logic [31:0] aop1, ra1, rb1, rz1, wd1, ccr1;
  logic [4:0]  wdest1;

  logic        iv3, rdy3, nop3, c3, v3, wv3, wr3, busy3;
  logic [31:0] aop3, ra3, rb3, rz3, wd3, ccr3;
  logic [4:0]  wdest3;

  int          checks = 0;
  int          passed = 0;
  logic [6:0]  m_ccr1;
  logic [255:0] g, e;

  // Behavioural ALU: returns {carry, overflow, result}
  function automatic logic [33:0] alu_f(input logic [5:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, v;
    c = 1'b0; v = 1'b0; s = '0;
    case (o)
      6'h01: begin s = {1'b0, x} + {1'b0, y}; r = s[31:0]; c = s[32]; v = (x[31] == y[31]) && (r[31] != x[31]); end
      6'h02: begin s = {1'b0, x} - {1'b0, y}; r = s[31:0]; c = s[32]; v = (x[31] != y[31]) && (r[31] != x[31]); end
      6'h03: r = x & y;
      6'h04: r = x | y;
      6'h05: r = x ^ y;
      default: r = y;
    endcase
    return {c, v, r};
  endfunction

  assign {c1, v1, rz1} = alu_f(aop1[5:0], ra1, rb1);
  assign {c3, v3, rz3} = alu_f(aop3[5:0], ra3, rb3);

  alu_sequencer #(.WIDTH(32), .ALU_LATENCY(1)) u_dut1 (
    .Clock(Clock), .Reset(Reset), .IssueValid(iv1), .IssueReady(rdy1),
    .IssueOp(op), .IssueFmt(fmt), .IssueA(a), .IssueB(b), .IssueImm(imm),
    .IssueUseImm(useimm), .IssueDest(dest), .ALU_Op(aop1), .ALU_RA(ra1),
    .ALU_RB(rb1), .ALU_NOP(nop1), .ALU_RZ(rz1), .ALU_C(c1), .ALU_V(v1),
    .WbValid(wv1), .WbReady(wr1), .WbData(wd1), .WbDest(wdest1),
    .CcrClear(clr), .CCR(ccr1), .Busy(busy1)
  );

  alu_sequencer #(.WIDTH(32), .ALU_LATENCY(3)) u_dut3 (
    .Clock(Clock), .Reset(Reset), .IssueValid(iv3), .IssueReady(rdy3),
    .IssueOp(op), .IssueFmt(fmt), .IssueA(a), .IssueB(b), .IssueImm(imm),
    .IssueUseImm(useimm), .IssueDest(dest), .ALU_Op(aop3), .ALU_RA(ra3),
    .ALU_RB(rb3), .ALU_NOP(nop3), .ALU_RZ(rz3), .ALU_C(c3), .ALU_V(v3),
    .WbValid(wv3), .WbReady(wr3), .WbData(wd3), .WbDest(wdest3),
    .CcrClear(clr), .CCR(ccr3), .Busy(busy3)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b1; iv1 = 1'b0; iv3 = 1'b0; wr1 = 1'b0; wr3 = 1'b0; clr = 1'b0;
    op = '0; fmt = '0; a = '0; b = '0; imm = '0; useimm = 1'b0; dest = '0;
    tick; tick;
    g = 256'({rdy1, wv1, wd1, wdest1, ccr1, aop1, ra1, rb1, nop1, busy1});
    e = 256'({1'b0, 1'b0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0});
    checks++;
    if (g !== e) $display("FAIL reset_state_lat1: got %h exp %h", g, e); else passed++;
    g = 256'({rdy3, wv3, wd3, wdest3, ccr3, aop3, ra3, rb3, nop3, busy3});
    checks++;
    if (g !== e) $display("FAIL reset_state_lat3: got %h exp %h", g, e); else passed++;
    Reset = 1'b0;
    #1;
    checks++;
    if ({rdy1, rdy3} !== 2'b11) $display("FAIL reset_release_ready: got %b exp 11", {rdy1, rdy3}); else passed++;
    m_ccr1 = '0;
  endtask

  task automatic test_add;
    op = 6'h01; fmt = 2'b00; a = 32'd5; b = 32'd7; useimm = 1'b0; dest = 5'd3;
    wr1 = 1'b1; iv1 = 1'b1;
    tick; iv1 = 1'b0;
    g = 256'({busy1, nop1, wv1, rdy1, aop1, ra1, rb1});
    e = 256'({1'b1, 1'b0, 1'b0, 1'b0, 32'd1, 32'd5, 32'd7});
    checks++;
    if (g !== e) $display("FAIL add_exec: got %h exp %h", g, e); else passed++;
    tick;
    g = 256'({wv1, wd1, wdest1, ccr1});
    e = 256'({1'b1, 32'd12, 5'd3, 32'd0});
    checks++;
    if (g !== e) $display("FAIL add_wb: got %h exp %h", g, e); else passed++;
    tick;
    g = 256'({wv1, rdy1, busy1, nop1, aop1, ra1});
    e = 256'({1'b0, 1'b1, 1'b0, 1'b1, 32'd1, 32'd5});
    checks++;
    if (g !== e) $display("FAIL add_idle_hold: got %h exp %h", g, e); else passed++;
    wr1 = 1'b0;
    m_ccr1 = 7'h00;
  endtask

  task automatic test_imm;
    op = 6'h01; a = 32'h8000_0001; b = 32'd9; imm = 32'hFFFF_FFFF; useimm = 1'b1; dest = 5'd7;
    iv1 = 1'b1; wr1 = 1'b1;
    tick; iv1 = 1'b0; useimm = 1'b0;
    checks++;
    if (rb1 !== 32'hFFFF_FFFF) $display("FAIL imm_rb: got %h exp ffffffff", rb1); else passed++;
    tick;
    g = 256'({wd1, wdest1, ccr1});
    e = 256'({32'h8000_0000, 5'd7, 32'h0000_0003});
    checks++;
    if (g !== e) $display("FAIL imm_flags: got %h exp %h", g, e); else passed++;
    tick; wr1 = 1'b0;
    m_ccr1 = 7'h03;
  endtask

  task automatic test_retire;
    iv1 = 1'b1; wr1 = 1'b1; fmt = 2'b00;
    op = 6'h3F; tick;
    g = 256'({ccr1, wv1, rdy1});
    e = 256'({32'h0000_0043, 1'b0, 1'b1});
    checks++;
    if (g !== e) $display("FAIL retire_nop: got %h exp %h", g, e); else passed++;
    op = 6'h20; tick;
    e = 256'({32'h0000_0013, 1'b0, 1'b1});
    g = 256'({ccr1, wv1, rdy1});
    checks++;
    if (g !== e) $display("FAIL retire_inr: got %h exp %h", g, e); else passed++;
    op = 6'h01; fmt = 2'b11; tick;
    e = 256'({32'h0000_0023, 1'b0, 1'b1});
    g = 256'({ccr1, wv1, rdy1});
    checks++;
    if (g !== e) $display("FAIL retire_ifnr: got %h exp %h", g, e); else passed++;
    iv1 = 1'b0; fmt = 2'b00; wr1 = 1'b0;
    m_ccr1 = 7'h23;
  endtask

  task automatic test_random(input int n);
    int          sel, w;
    logic [5:0]  o;
    logic [1:0]  f;
    logic [31:0] a_s, rb_e;
    logic [4:0]  d_s;
    logic [33:0] res;
    logic        c_clr;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 9);
      f = 2'($urandom_range(0, 2));
      o = 6'($urandom_range(0, 15));
      if (sel == 0) begin f = 2'b11; o = 6'($urandom); end
      else if (sel == 1) o = 6'h3F;
      else if (sel == 2) o = 6'($urandom_range(16, 62));
      a = $urandom; b = ($urandom_range(0, 7) == 0) ? a : $urandom; imm = $urandom;
      useimm = 1'($urandom_range(0, 1)); dest = 5'($urandom);
      c_clr = ($urandom_range(0, 3) == 0);
      op = o; fmt = f; clr = c_clr; iv1 = 1'b1; wr1 = 1'b0;
      a_s = a; d_s = dest; rb_e = useimm ? imm : b;
      if (c_clr) m_ccr1 = '0;
      tick;
      iv1 = 1'b0; clr = 1'b0;
      a = $urandom; b = $urandom; imm = $urandom; dest = 5'($urandom);
      if (f == 2'b11 || o == 6'h3F || o > 6'h0F) begin
        m_ccr1[6:4] = (f == 2'b11) ? 3'b010 : (o == 6'h3F) ? 3'b100 : 3'b001;
        g = 256'({ccr1, wv1, rdy1, busy1});
        e = 256'({25'd0, m_ccr1, 1'b0, 1'b1, 1'b0});
        checks++;
        if (g !== e) $display("FAIL rand_retire[%0d]: got %h exp %h", i, g, e); else passed++;
      end else begin
        res = alu_f(o, a_s, rb_e);
        g = 256'({aop1, ra1, rb1, nop1, ccr1});
        e = 256'({26'd0, o, a_s, rb_e, 1'b0, 25'd0, m_ccr1});
        checks++;
        if (g !== e) $display("FAIL rand_issue[%0d]: got %h exp %h", i, g, e); else passed++;
        tick;
        m_ccr1[6:4] = 3'b000;
        m_ccr1[3] = (res[31:0] == 32'd0);
        m_ccr1[1] = res[31];
        m_ccr1[0] = res[33];
`ifdef ALU_SEQ_STICKY_OVF_EN
        m_ccr1[2] = m_ccr1[2] | res[32];
`else
        m_ccr1[2] = res[32];
`endif
        g = 256'({wv1, wd1, wdest1, ccr1});
        e = 256'({1'b1, res[31:0], d_s, 25'd0, m_ccr1});
        checks++;
        if (g !== e) $display("FAIL rand_capture[%0d]: got %h exp %h", i, g, e); else passed++;
        w = $urandom_range(0, 3);
        repeat (w) begin
          tick;
          g = 256'({wv1, wd1, wdest1, rdy1});
          e = 256'({1'b1, res[31:0], d_s, 1'b0});
          checks++;
          if (g !== e) $display("FAIL rand_hold[%0d]: got %h exp %h", i, g, e); else passed++;
        end
        wr1 = 1'b1; tick; wr1 = 1'b0;
        g = 256'({wv1, rdy1, busy1});
        e = 256'({1'b0, 1'b1, 1'b0});
        checks++;
        if (g !== e) $display("FAIL rand_release[%0d]: got %h exp %h", i, g, e); else passed++;
      end
    end
  endtask

  task automatic test_sticky;
    logic sticky;
`ifdef ALU_SEQ_STICKY_OVF_EN
    sticky = 1'b1;
`else
    sticky = 1'b0;
`endif
    wr1 = 1'b1; fmt = 2'b00; useimm = 1'b0;
    clr = 1'b1; tick; clr = 1'b0;
    checks++;
    if (ccr1 !== 32'd0) $display("FAIL sticky_clr0: got %h exp 0", ccr1); else passed++;
    op = 6'h01; a = 32'h7FFF_FFFF; b = 32'd1; iv1 = 1'b1; tick; iv1 = 1'b0; tick;
    checks++;
    if (ccr1 !== 32'h06) $display("FAIL sticky_ovf: got %h exp 6", ccr1); else passed++;
    tick;
    op = 6'h03; a = 32'h0F; b = 32'hF0; iv1 = 1'b1; tick; iv1 = 1'b0; tick;
    e = sticky ? 256'h0C : 256'h08; g = 256'(ccr1);
    checks++;
    if (g !== e) $display("FAIL sticky_after_zero: got %h exp %h", g, e); else passed++;
    tick;
    op = 6'h3F; iv1 = 1'b1; tick; iv1 = 1'b0;
    e = sticky ? 256'h4C : 256'h48; g = 256'(ccr1);
    checks++;
    if (g !== e) $display("FAIL sticky_after_nop: got %h exp %h", g, e); else passed++;
    op = 6'h20; iv1 = 1'b1; clr = 1'b1; tick; iv1 = 1'b0; clr = 1'b0;
    checks++;
    if (ccr1 !== 32'h10) $display("FAIL clr_with_retire: got %h exp 10", ccr1); else passed++;
    op = 6'h01; a = 32'h7FFF_FFFF; b = 32'd1; iv1 = 1'b1; tick; iv1 = 1'b0; tick; tick;
    op = 6'h03; a = 32'h0F; b = 32'hF0; iv1 = 1'b1; tick; iv1 = 1'b0; clr = 1'b1; tick; clr = 1'b0;
    checks++;
    if (ccr1 !== 32'h08) $display("FAIL clr_with_capture: got %h exp 8", ccr1); else passed++;
    tick;
    clr = 1'b1; tick; clr = 1'b0;
    checks++;
    if (ccr1 !== 32'd0) $display("FAIL sticky_clr_final: got %h exp 0", ccr1); else passed++;
    wr1 = 1'b0;
    m_ccr1 = '0;
  endtask

  task automatic test_stall;
    op = 6'h02; fmt = 2'b00; a = 32'd100; b = 32'd58; useimm = 1'b0; dest = 5'd9;
    iv3 = 1'b1; wr3 = 1'b0;
    tick; iv3 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      g = 256'({wv3, busy3, nop3});
      e = 256'({1'b0, 1'b1, 1'b0});
      checks++;
      if (g !== e) $display("FAIL lat3_exec[%0d]: got %h exp %h", j, g, e); else passed++;
      tick;
    end
    g = 256'({wv3, wd3, wdest3});
    e = 256'({1'b1, 32'd42, 5'd9});
    checks++;
    if (g !== e) $display("FAIL lat3_wb: got %h exp %h", g, e); else passed++;
    op = 6'h04; a = 32'h55; b = 32'hA0; dest = 5'd2; iv3 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick;
      g = 256'({wv3, wd3, wdest3, rdy3, ra3});
      e = 256'({1'b1, 32'd42, 5'd9, 1'b0, 32'd100});
      checks++;
      if (g !== e) $display("FAIL stall_hold[%0d]: got %h exp %h", j, g, e); else passed++;
    end
    wr3 = 1'b1; tick; wr3 = 1'b0;
    g = 256'({wv3, rdy3});
    e = 256'({1'b0, 1'b1});
    checks++;
    if (g !== e) $display("FAIL stall_release: got %h exp %h", g, e); else passed++;
    tick; iv3 = 1'b0; wr3 = 1'b1;
    g = 256'({busy3, ra3, rb3});
    e = 256'({1'b1, 32'h55, 32'hA0});
    checks++;
    if (g !== e) $display("FAIL next_accept: got %h exp %h", g, e); else passed++;
    for (int j = 0; j < 3; j++) begin
      g = 256'({wv3, busy3});
      e = 256'({1'b0, 1'b1});
      checks++;
      if (g !== e) $display("FAIL early_ready_ignored[%0d]: got %h exp %h", j, g, e); else passed++;
      tick;
    end
    g = 256'({wv3, wd3, wdest3});
    e = 256'({1'b1, 32'hF5, 5'd2});
    checks++;
    if (g !== e) $display("FAIL second_wb: got %h exp %h", g, e); else passed++;
    tick; wr3 = 1'b0;
    g = 256'({wv3, rdy3});
    e = 256'({1'b0, 1'b1});
    checks++;
    if (g !== e) $display("FAIL second_release: got %h exp %h", g, e); else passed++;
  endtask

  task automatic test_reset_exec;
    op = 6'h01; fmt = 2'b00; a = 32'd3; b = 32'd4; useimm = 1'b0; dest = 5'd1;
    iv3 = 1'b1; wr3 = 1'b1;
    tick; iv3 = 1'b0;
    checks++;
    if (busy3 !== 1'b1) $display("FAIL rst_exec_busy: got %b exp 1", busy3); else passed++;
    tick;
    Reset = 1'b1; tick; Reset = 1'b0;
    m_ccr1 = '0;
    g = 256'({wv3, ccr3, busy3, nop3, ra3, wd3});
    e = 256'({1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd0});
    checks++;
    if (g !== e) $display("FAIL rst_exec_state: got %h exp %h", g, e); else passed++;
    #1;
    checks++;
    if (rdy3 !== 1'b1) $display("FAIL rst_exec_ready: got %b exp 1", rdy3); else passed++;
    for (int j = 0; j < 6; j++) begin
      tick;
      checks++;
      if (wv3 !== 1'b0) $display("FAIL rst_no_wb[%0d]: got %b exp 0", j, wv3); else passed++;
    end
    wr3 = 1'b0;
  endtask

  initial begin
    test_reset;
    test_add;
    test_imm;
    test_retire;
    test_random(40);
    test_sticky;
    test_stall;
    test_reset_exec;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
